inport_controller: RTL

- Producer side of the CPU input port.
- Samples the raw DE0-CV switches and one raw push-button (active-low key), debounces the key, and latches the switch value on each clean press.
- Presents the latched value to the datapath inport as a zero-extended 32-bit word with a ready flag.
- The control unit's inport-read strobe consumes the value (a one-entry buffer with handshake and overrun detection).

---
 rtl/inport_controller_pkg.sv | 18 +
 rtl/inport_controller_key_debouncer.sv | 59 +++++
 rtl/inport_controller.sv | 104 ++++++++++
 3 files changed

// File: rtl/inport_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inport_controller_pkg
// Description : Shared constants and state encoding for the CPU input port.
// Revision    : 1.0 - initial release
// ============================================================================
package inport_controller_pkg;

    localparam int INPORT_WORD_WIDTH       = 32;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

    typedef enum logic [0:0] {
        INPORT_EMPTY = 1'b0,
        INPORT_FULL  = 1'b1
    } inport_state_t;

endpackage
`default_nettype wire

// File: rtl/inport_controller_key_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : key_debouncer
// Description : 2-flop synchronizer plus counter debouncer for an active-low
//               key; pulses out_fall_pulse on the edge the level drops.
// Revision    : 1.0 - initial release
// ============================================================================
module key_debouncer
    import inport_controller_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic in_raw,
    output logic out_level,
    output logic out_fall_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;
    logic             w_differ;
    logic             w_flip;

    assign w_differ = (r_sync2 != r_level);
    assign w_flip   = w_differ && (r_cnt == c_cnt_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= in_raw;
            r_sync2 <= r_sync1;
            if (w_flip) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else if (w_differ) begin
                r_cnt   <= r_cnt + 1'b1;
            end else begin
                // Any agreeing cycle restarts the count, rejecting short bounces.
                r_cnt   <= '0;
            end
        end
    end

    // Combinational so the consumer acts on the same edge the level flips.
    assign out_fall_pulse = w_flip && r_level;
    assign out_level      = r_level;

endmodule
`default_nettype wire

// File: rtl/inport_controller.sv
`default_nettype none
// ============================================================================
// Module      : inport_controller
// Description : Debounced-key switch capture into a one-entry buffer feeding
//               the CPU datapath inport, with read handshake and overrun flag.
// Revision    : 1.0 - initial release
// ============================================================================
module inport_controller
    import inport_controller_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_WIDTH-1:0]        in_switches,
    input  logic                         in_button,
    input  logic                         in_inport_read,
    output logic [INPORT_WORD_WIDTH-1:0] out_inport,
    output logic                         out_ready,
    output logic                         out_overrun
);

    logic [DATA_WIDTH-1:0] r_sw_sync1;
    logic [DATA_WIDTH-1:0] r_sw_sync2;
    logic                  r_prev_read;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_overrun;
    inport_state_t         r_state;

    logic [DATA_WIDTH-1:0] w_data_nxt;
    logic                  w_overrun_nxt;
    inport_state_t         w_state_nxt;
    logic                  w_press;
    logic                  w_read_evt;
    logic                  w_key_level;

    key_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_debouncer (
        .clk            (clk),
        .reset          (reset),
        .in_raw         (in_button),
        .out_level      (w_key_level),
        .out_fall_pulse (w_press)
    );

    assign w_read_evt = in_inport_read & ~r_prev_read;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sw_sync1  <= '0;
            r_sw_sync2  <= '0;
            r_prev_read <= 1'b0;
            r_data      <= '0;
            r_overrun   <= 1'b0;
            r_state     <= INPORT_EMPTY;
        end else begin
            r_sw_sync1  <= in_switches;
            r_sw_sync2  <= r_sw_sync1;
            r_prev_read <= in_inport_read;
            r_data      <= w_data_nxt;
            r_overrun   <= w_overrun_nxt;
            r_state     <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_data_nxt    = r_data;
        w_overrun_nxt = r_overrun;
        case (r_state)
            INPORT_EMPTY: begin
                if (w_press) begin
                    w_data_nxt  = r_sw_sync2;
                    w_state_nxt = INPORT_FULL;
                end
            end
            INPORT_FULL: begin
                if (w_read_evt) begin
                    // A read clears overrun; a coincident press refills the slot.
                    w_overrun_nxt = 1'b0;
                    if (w_press) begin
                        w_data_nxt = r_sw_sync2;
                    end else begin
                        w_state_nxt = INPORT_EMPTY;
                    end
                end else if (w_press) begin
                    w_overrun_nxt = 1'b1;
                end
            end
            default: w_state_nxt = INPORT_EMPTY;
        endcase
    end

    assign out_inport  = INPORT_WORD_WIDTH'(r_data);
    assign out_ready   = (r_state == INPORT_FULL);
    assign out_overrun = r_overrun;

    logic w_unused;
    assign w_unused = w_key_level;

endmodule
`default_nettype wire
